// File: rtl/cellrv32_package.sv
// Shared FPU co-processor package (slice used by the float-to-integer unit).
// Holds the operand class indices, exception flag indices, rounding-mode
// encodings and the float-to-integer converter state type.
package cellrv32_package;

  // operand class indices (one-hot class vector, RISC-V fclass order)
  localparam int fp_class_neg_inf_c    = 0;
  localparam int fp_class_neg_norm_c   = 1;
  localparam int fp_class_neg_denorm_c = 2;
  localparam int fp_class_neg_zero_c   = 3;
  localparam int fp_class_pos_zero_c   = 4;
  localparam int fp_class_pos_denorm_c = 5;
  localparam int fp_class_pos_norm_c   = 6;
  localparam int fp_class_pos_inf_c    = 7;
  localparam int fp_class_snan_c       = 8;
  localparam int fp_class_qnan_c       = 9;

  // exception flag indices
  localparam int fp_exc_nv_c = 0; // invalid
  localparam int fp_exc_dz_c = 1; // divide by zero
  localparam int fp_exc_of_c = 2; // overflow
  localparam int fp_exc_uf_c = 3; // underflow
  localparam int fp_exc_nx_c = 4; // inexact

  // rounding modes
  localparam logic [2:0] rm_rne_c = 3'b000;
  localparam logic [2:0] rm_rtz_c = 3'b001;
  localparam logic [2:0] rm_rdn_c = 3'b010;
  localparam logic [2:0] rm_rup_c = 3'b011;
  localparam logic [2:0] rm_rmm_c = 3'b100;

  typedef enum logic [2:0] {
    F2I_IDLE,
    F2I_PREPARE,
    F2I_SHIFT,
    F2I_ROUND,
    F2I_FINALIZE
  } fpu_f2i_state_t;

endpackage

// File: rtl/cellrv32_cpu_cp_fpu_f2i_round.sv
// Float-to-integer rounding decision (combinational).
// Ports:
//   rmode    : rounding mode (unknown encodings behave as RTZ)
//   sign     : operand sign
//   g, r, s  : guard, round and sticky bits below the integer LSB
//   int_part : truncated integer magnitude
//   inc      : round-up decision
//   inexact  : any discarded fraction bit set
//   mag      : int_part + inc, one bit wider so a carry-out is visible
module cellrv32_cpu_cp_fpu_f2i_round
  import cellrv32_package::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      rmode,
  input  logic            sign,
  input  logic            g,
  input  logic            r,
  input  logic            s,
  input  logic [XLEN-1:0] int_part,
  output logic            inc,
  output logic            inexact,
  output logic [XLEN:0]   mag
);

  assign inexact = g | r | s;

  always_comb begin
    inc = 1'b0;
    case (rmode)
      rm_rne_c: inc = g & (r | s | int_part[0]);
      rm_rdn_c: inc = sign & inexact;
      rm_rup_c: inc = ~sign & inexact;
      rm_rmm_c: inc = g;
      default:  inc = 1'b0;
    endcase
  end

  assign mag = {1'b0, int_part} + {{XLEN{1'b0}}, inc};

endmodule

// File: rtl/cellrv32_cpu_cp_fpu_f2i_gen.sv
// Single-precision float to XLEN-bit integer converter (FCVT.W/WU/L/LU).
// The operand is normalised into a fixed-point working register W
// (integer part W[XLEN+22:23], fraction W[22:0]) by an iterative
// SHIFT_STEP-bit shifter, then rounded and saturated.
// Optional build macro: CELLRV32_FPU_F2I_BARREL_EN selects a single-cycle
// barrel shift instead of the iterative shifter.
// Ports:
//   clk_i, rstn_i     : clock, async active-low reset
//   start_i           : start conversion (accepted in IDLE only)
//   kill_i            : abort, back to IDLE, outputs untouched
//   rmode_i, funct_i  : rounding mode, 0 signed / 1 unsigned
//   sign_i, exponent_i, mantissa_i, class_i : operand
//   result_o, flags_o : registered result and exception flags
//   done_o            : one-cycle completion pulse
//   busy_o            : high while not IDLE
module cellrv32_cpu_cp_fpu_f2i_gen
  import cellrv32_package::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      rmode_i,
  input  logic            funct_i,
  input  logic            sign_i,
  input  logic [7:0]      exponent_i,
  input  logic [22:0]     mantissa_i,
  input  logic [9:0]      class_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      flags_o,
  output logic            done_o,
  output logic            busy_o
);

  localparam int WW = XLEN + 23;
  localparam int CW = 7;
  localparam logic [XLEN:0] SMAX     = {2'b00, {(XLEN-1){1'b1}}}; // 2^(XLEN-1)-1
  localparam logic [XLEN:0] SMIN_MAG = {2'b01, {(XLEN-1){1'b0}}}; // 2^(XLEN-1)

  fpu_f2i_state_t state, state_nxt;

  logic          sign_q, funct_q;
  logic [2:0]    rmode_q;
  logic [7:0]    exp_q;
  logic [22:0]   mant_q;
  logic [9:0]    class_q;
  logic [WW-1:0] w_q;
  logic [CW-1:0] cnt_q;
  logic          sticky_q, over_q, inexact_q;
  logic [XLEN:0] mag_q;

  logic          is_num, is_zero, is_nan, over_det;
  logic          rnd_inexact, rnd_inc_unused;
  logic [XLEN:0] rnd_mag;
  logic [XLEN-1:0] res_fin;
  logic [4:0]      flg_fin;
`ifndef CELLRV32_FPU_F2I_BARREL_EN
  logic [CW-1:0] amt;
`endif

  // only finite non-zero operands go through the shifter; everything else
  // is resolved directly from the class in FINALIZE
  assign is_num   = class_q[fp_class_neg_norm_c] | class_q[fp_class_neg_denorm_c] |
                    class_q[fp_class_pos_norm_c] | class_q[fp_class_pos_denorm_c];
  assign is_zero  = class_q[fp_class_neg_zero_c] | class_q[fp_class_pos_zero_c];
  assign is_nan   = class_q[fp_class_snan_c] | class_q[fp_class_qnan_c];
  assign over_det = {1'b0, exp_q} > 9'(126 + XLEN);
  assign busy_o   = (state != F2I_IDLE);

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= F2I_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      F2I_IDLE:     if (start_i) state_nxt = F2I_PREPARE;
      F2I_PREPARE:  state_nxt = (!is_num || over_det) ? F2I_FINALIZE : F2I_SHIFT;
`ifdef CELLRV32_FPU_F2I_BARREL_EN
      F2I_SHIFT:    state_nxt = F2I_ROUND;
`else
      F2I_SHIFT:    if (cnt_q == '0) state_nxt = F2I_ROUND;
`endif
      F2I_ROUND:    state_nxt = F2I_FINALIZE;
      F2I_FINALIZE: state_nxt = F2I_IDLE;
      default:      state_nxt = F2I_IDLE;
    endcase
    if (kill_i) state_nxt = F2I_IDLE;
  end

`ifndef CELLRV32_FPU_F2I_BARREL_EN
  assign amt = (cnt_q > CW'(SHIFT_STEP)) ? CW'(SHIFT_STEP) : cnt_q;
`endif

  // ---------------- datapath ----------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sign_q    <= 1'b0;
      funct_q   <= 1'b0;
      rmode_q   <= '0;
      exp_q     <= '0;
      mant_q    <= '0;
      class_q   <= '0;
      w_q       <= '0;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
      over_q    <= 1'b0;
      inexact_q <= 1'b0;
      mag_q     <= '0;
    end else begin
      case (state)
        F2I_IDLE: if (start_i && !kill_i) begin
          sign_q  <= sign_i;
          funct_q <= funct_i;
          rmode_q <= rmode_i;
          exp_q   <= exponent_i;
          mant_q  <= mantissa_i;
          class_q <= class_i;
        end
        F2I_PREPARE: begin
          over_q   <= over_det;
          w_q      <= '0;
          cnt_q    <= '0;
          sticky_q <= 1'b0;
          if (exp_q >= 8'd127) begin
            w_q[23:0] <= {1'b1, mant_q};
            cnt_q     <= CW'(exp_q - 8'd127);
          end else if (exp_q == 8'd126) begin
            // 0.5 <= |x| < 1: hidden bit lands on G, mant[0] falls below S
            w_q[22:0] <= {1'b1, mant_q[22:1]};
            sticky_q  <= mant_q[0];
          end else begin
            // |x| < 0.5: only "something non-zero below R" survives
            sticky_q <= 1'b1;
          end
        end
        F2I_SHIFT: begin
`ifdef CELLRV32_FPU_F2I_BARREL_EN
          w_q   <= w_q << cnt_q;
          cnt_q <= '0;
`else
          if (cnt_q != '0) begin
            w_q   <= w_q << amt;
            cnt_q <= cnt_q - amt;
          end
`endif
        end
        F2I_ROUND: begin
          mag_q     <= rnd_mag;
          inexact_q <= rnd_inexact;
        end
        default: ;
      endcase
    end
  end

  // the increment is already folded into rnd_mag
  cellrv32_cpu_cp_fpu_f2i_round #(.XLEN(XLEN)) u_round (
    .rmode    (rmode_q),
    .sign     (sign_q),
    .g        (w_q[22]),
    .r        (w_q[21]),
    .s        ((|w_q[20:0]) | sticky_q),
    .int_part (w_q[WW-1:23]),
    .inc      (rnd_inc_unused),
    .inexact  (rnd_inexact),
    .mag      (rnd_mag)
  );

  // ---------------- saturation / final result ----------------
  always_comb begin
    res_fin = '0;
    flg_fin = '0;
    if (is_zero) begin
      res_fin = '0;
    end else if (!funct_q) begin
      if (is_nan || class_q[fp_class_pos_inf_c] || (!sign_q && (over_q || mag_q > SMAX))) begin
        res_fin              = {1'b0, {(XLEN-1){1'b1}}};
        flg_fin[fp_exc_nv_c] = 1'b1;
      end else if (class_q[fp_class_neg_inf_c] || (sign_q && (over_q || mag_q > SMIN_MAG))) begin
        res_fin              = {1'b1, {(XLEN-1){1'b0}}};
        flg_fin[fp_exc_nv_c] = 1'b1;
      end else begin
        res_fin              = sign_q ? ('0 - mag_q[XLEN-1:0]) : mag_q[XLEN-1:0];
        flg_fin[fp_exc_nx_c] = inexact_q;
      end
    end else begin
      if (is_nan || class_q[fp_class_pos_inf_c] || (!sign_q && (over_q || mag_q[XLEN]))) begin
        res_fin              = '1;
        flg_fin[fp_exc_nv_c] = 1'b1;
      end else if (class_q[fp_class_neg_inf_c] || (sign_q && (over_q || mag_q != '0))) begin
        res_fin              = '0;
        flg_fin[fp_exc_nv_c] = 1'b1;
      end else begin
        // negative operands reaching here rounded to zero
        res_fin              = sign_q ? '0 : mag_q[XLEN-1:0];
        flg_fin[fp_exc_nx_c] = inexact_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      result_o <= '0;
      flags_o  <= '0;
      done_o   <= 1'b0;
    end else begin
      done_o <= (state == F2I_FINALIZE) && !kill_i;
      if ((state == F2I_FINALIZE) && !kill_i) begin
        result_o <= res_fin;
        flags_o  <= flg_fin;
      end
    end
  end

endmodule

// File: tb/tb_cellrv32_cpu_cp_fpu_f2i_gen.sv
// Testbench: 32-bit (1-bit steps) and 64-bit (4-bit steps) converters run
// side by side on the same operands and are compared against an exact
// arithmetic reference model.
module tb_cellrv32_cpu_cp_fpu_f2i_gen;
  import cellrv32_package::*;

  logic        clk = 1'b0, rstn = 1'b0, start = 1'b0, kill = 1'b0;
  logic [2:0]  rmode = '0;
  logic        funct = 1'b0, sgn = 1'b0;
  logic [7:0]  expo = '0;
  logic [22:0] mant = '0;
  logic [9:0]  cls = '0;
  logic [31:0] res32;
  logic [63:0] res64;
  logic [4:0]  flg32, flg64;
  logic        done32, done64, busy32, busy64;

  int n_tests = 0, n_fail = 0;
  logic [63:0] got_r32, got_r64, exp_r32, exp_r64;
  logic [4:0]  got_f32, got_f64, exp_f32, exp_f64;
  int          got_l32, got_l64;

  always #5 clk = ~clk;

  cellrv32_cpu_cp_fpu_f2i_gen #(.XLEN(32), .SHIFT_STEP(1)) u_dut32 (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .kill_i(kill), .rmode_i(rmode),
    .funct_i(funct), .sign_i(sgn), .exponent_i(expo), .mantissa_i(mant), .class_i(cls),
    .result_o(res32), .flags_o(flg32), .done_o(done32), .busy_o(busy32));

  cellrv32_cpu_cp_fpu_f2i_gen #(.XLEN(64), .SHIFT_STEP(4)) u_dut64 (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .kill_i(kill), .rmode_i(rmode),
    .funct_i(funct), .sign_i(sgn), .exponent_i(expo), .mantissa_i(mant), .class_i(cls),
    .result_o(res64), .flags_o(flg64), .done_o(done64), .busy_o(busy64));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, want);
    end
  endtask

  function automatic logic [9:0] cls_of(logic s, logic [7:0] e, logic [22:0] m);
    logic [9:0] c;
    c = '0;
    if (e == 8'hFF) begin
      if (m == '0)   c[s ? fp_class_neg_inf_c : fp_class_pos_inf_c] = 1'b1;
      else if (m[22]) c[fp_class_qnan_c] = 1'b1;
      else            c[fp_class_snan_c] = 1'b1;
    end else if (e == 8'h00) begin
      if (m == '0) c[s ? fp_class_neg_zero_c : fp_class_pos_zero_c] = 1'b1;
      else         c[s ? fp_class_neg_denorm_c : fp_class_pos_denorm_c] = 1'b1;
    end else begin
      c[s ? fp_class_neg_norm_c : fp_class_pos_norm_c] = 1'b1;
    end
    return c;
  endfunction

  function automatic int lat_of(int xl, int step, logic [7:0] e, logic [9:0] c);
    if (c[fp_class_pos_inf_c] | c[fp_class_neg_inf_c] | c[fp_class_pos_zero_c] |
        c[fp_class_neg_zero_c] | c[fp_class_snan_c] | c[fp_class_qnan_c] || int'(e) > 126 + xl)
      return 3;
`ifdef CELLRV32_FPU_F2I_BARREL_EN
    return 5 + 0 * step;
`else
    return 5 + ((int'(e) > 127) ? (int'(e) - 127 + step - 1) / step : 0);
`endif
  endfunction

  // exact value = (2^23 + mant) * 2^(exp-150); round, then saturate
  task automatic ref_model(input int xl, input logic s, input logic [7:0] e, input logic [22:0] m,
                           input logic [9:0] c, input logic [2:0] rm, input logic fu,
                           output logic [63:0] res, output logic [4:0] flg);
    logic [127:0] sig, ip, rem, half, mag, lim, mask;
    logic big, inx, inc, se;
    int ee, sh;
    sig  = {104'd0, 1'b1, m};
    lim  = 128'd1 << (xl - 1);
    mask = (128'd1 << xl) - 128'd1;
    ee   = int'(e);
    res = '0; flg = '0; ip = '0; rem = '0; half = 128'd1; mag = '0; inx = 1'b0; inc = 1'b0;
    se  = s;
    if (c[fp_class_pos_zero_c] | c[fp_class_neg_zero_c]) return;
    big = (ee > 126 + xl);
    if (c[fp_class_snan_c] | c[fp_class_qnan_c]) begin big = 1'b1; se = 1'b0; end
    if (c[fp_class_pos_inf_c] | c[fp_class_neg_inf_c]) big = 1'b1;
    if (!big) begin
      if (ee >= 150) ip = sig << (ee - 150);
      else if (ee >= 126) begin
        sh   = 150 - ee;
        ip   = sig >> sh;
        rem  = sig & ((128'd1 << sh) - 128'd1);
        half = 128'd1 << (sh - 1);
      end else begin
        rem = 128'd1; half = 128'd2; // nonzero, below one half
      end
      inx = (rem != '0);
      case (rm)
        3'b000: inc = (rem > half) || (rem == half && ip[0]);
        3'b010: inc = se & inx;
        3'b011: inc = ~se & inx;
        3'b100: inc = (rem >= half) && inx;
        default: inc = 1'b0;
      endcase
      mag = ip + {127'd0, inc};
    end
    if (!fu) begin
      if (!se && (big || mag > lim - 128'd1)) begin res = 64'(lim - 128'd1); flg[fp_exc_nv_c] = 1'b1; end
      else if (se && (big || mag > lim)) begin res = 64'((~lim + 128'd1) & mask); flg[fp_exc_nv_c] = 1'b1; end
      else begin res = 64'((se ? (~mag + 128'd1) : mag) & mask); flg[fp_exc_nx_c] = inx; end
    end else begin
      if (!se && (big || mag > mask)) begin res = 64'(mask); flg[fp_exc_nv_c] = 1'b1; end
      else if (se && (big || mag != '0)) begin res = '0; flg[fp_exc_nv_c] = 1'b1; end
      else begin res = 64'(mag); flg[fp_exc_nx_c] = inx; end
    end
  endtask

  // called just after a rising edge; start is high during cycle 0
  task automatic run_op(input string tag, input logic s, input logic [7:0] e, input logic [22:0] m,
                        input logic [9:0] c, input logic [2:0] rm, input logic fu);
    int cyc;
    ref_model(32, s, e, m, c, rm, fu, exp_r32, exp_f32);
    ref_model(64, s, e, m, c, rm, fu, exp_r64, exp_f64);
    sgn = s; expo = e; mant = m; cls = c; rmode = rm; funct = fu; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    sgn = ~s; expo = ~e; mant = ~m; rmode = ~rm; // live inputs must not matter
    cyc = 1; got_l32 = -1; got_l64 = -1;
    while ((got_l32 < 0 || got_l64 < 0) && cyc < 200) begin
      @(negedge clk);
      if (done32 && got_l32 < 0) begin got_l32 = cyc; got_r32 = {32'd0, res32}; got_f32 = flg32; end
      if (done64 && got_l64 < 0) begin got_l64 = cyc; got_r64 = res64; got_f64 = flg64; end
      @(posedge clk); #1; cyc++;
    end
    chk({tag, "_lat32"}, 64'(got_l32), 64'(lat_of(32, 1, e, c)));
    chk({tag, "_lat64"}, 64'(got_l64), 64'(lat_of(64, 4, e, c)));
    chk({tag, "_res32"}, got_r32, exp_r32);
    chk({tag, "_flg32"}, 64'(got_f32), 64'(exp_f32));
    chk({tag, "_res64"}, got_r64, exp_r64);
    chk({tag, "_flg64"}, 64'(got_f64), 64'(exp_f64));
  endtask

  initial begin
    logic s; logic [7:0] e; logic [22:0] m; int sel, seen;
    #12;
    chk("rst_res32", {32'd0, res32}, 64'd0);
    chk("rst_res64", res64, 64'd0);
    chk("rst_flags", {54'd0, flg32, flg64}, 64'd0);
    chk("rst_done_busy", {60'd0, done32, done64, busy32, busy64}, 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // 3.5 RNE signed -> 4, NX
    run_op("t1", 1'b0, 8'd128, 23'h600000, cls_of(1'b0, 8'd128, 23'h600000), rm_rne_c, 1'b0);
    chk("t1_const", got_r32, 64'd4);
    chk("t1_nx", 64'(got_f32), 64'h10);
`ifndef CELLRV32_FPU_F2I_BARREL_EN
    chk("t1_cycle", 64'(got_l32), 64'd6);
`endif
    // -2.5 in RNE / RMM / RUP
    run_op("t2rne", 1'b1, 8'd128, 23'h200000, cls_of(1'b1, 8'd128, 23'h200000), rm_rne_c, 1'b0);
    chk("t2rne_const", got_r32, 64'hFFFFFFFE);
    run_op("t2rmm", 1'b1, 8'd128, 23'h200000, cls_of(1'b1, 8'd128, 23'h200000), rm_rmm_c, 1'b0);
    chk("t2rmm_const", got_r32, 64'hFFFFFFFD);
    run_op("t2rup", 1'b1, 8'd128, 23'h200000, cls_of(1'b1, 8'd128, 23'h200000), rm_rup_c, 1'b0);
    chk("t2rup_const", got_r32, 64'hFFFFFFFE);
    // 2^31 signed / unsigned
    run_op("t3s", 1'b0, 8'd158, 23'h0, cls_of(1'b0, 8'd158, 23'h0), rm_rne_c, 1'b0);
    chk("t3s_const", got_r32, 64'h7FFFFFFF);
    chk("t3s_nv", 64'(got_f32), 64'h01);
    run_op("t3u", 1'b0, 8'd158, 23'h0, cls_of(1'b0, 8'd158, 23'h0), rm_rne_c, 1'b1);
    chk("t3u_const", got_r32, 64'h80000000);
    chk("t3u_noflag", 64'(got_f32), 64'h00);
    // -0.3 unsigned RTZ / RDN
    run_op("t4rtz", 1'b1, 8'h7D, 23'h19999A, cls_of(1'b1, 8'h7D, 23'h19999A), rm_rtz_c, 1'b1);
    chk("t4rtz_nx", 64'(got_f32), 64'h10);
    run_op("t4rdn", 1'b1, 8'h7D, 23'h19999A, cls_of(1'b1, 8'h7D, 23'h19999A), rm_rdn_c, 1'b1);
    chk("t4rdn_nv", 64'(got_f32), 64'h01);
    // qNaN signed, -inf unsigned
    run_op("t5nan", 1'b0, 8'hFF, 23'h400000, 10'b1 << fp_class_qnan_c, rm_rne_c, 1'b0);
    chk("t5nan_const", got_r64, 64'h7FFFFFFFFFFFFFFF);
    chk("t5nan_cycle", 64'(got_l64), 64'd3);
    run_op("t5ninf", 1'b1, 8'hFF, 23'h0, cls_of(1'b1, 8'hFF, 23'h0), rm_rne_c, 1'b1);
    chk("t5ninf_const", got_r64, 64'd0);
    // zero, subnormal, exp==126, exp at the 64-bit overflow edge
    run_op("zero", 1'b1, 8'd0, 23'h0, cls_of(1'b1, 8'd0, 23'h0), rm_rup_c, 1'b0);
    run_op("sub", 1'b0, 8'd0, 23'h1, cls_of(1'b0, 8'd0, 23'h1), rm_rup_c, 1'b0);
    run_op("half", 1'b0, 8'd126, 23'h0, cls_of(1'b0, 8'd126, 23'h0), rm_rne_c, 1'b0);
    run_op("e190", 1'b0, 8'd190, 23'h7FFFFF, cls_of(1'b0, 8'd190, 23'h7FFFFF), rm_rne_c, 1'b1);
    run_op("e191", 1'b1, 8'd191, 23'h0, cls_of(1'b1, 8'd191, 23'h0), rm_rne_c, 1'b0);

    // abort in the second SHIFT cycle
    run_op("prek", 1'b0, 8'd128, 23'h600000, cls_of(1'b0, 8'd128, 23'h600000), rm_rne_c, 1'b0);
    sgn = 1'b0; expo = 8'd150; mant = 23'h123456; cls = cls_of(1'b0, 8'd150, 23'h123456);
    rmode = rm_rne_c; funct = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; // cycle 1
    @(posedge clk); #1;               // cycle 2
    @(posedge clk); #1;               // cycle 3
    chk("kill_busy_before", {62'd0, busy32, busy64}, 64'd3);
    kill = 1'b1; start = 1'b1;
    @(posedge clk); #1; kill = 1'b0; start = 1'b0;
    chk("kill_busy_after", {62'd0, busy32, busy64}, 64'd0);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done32 || done64) seen++;
    end
    @(posedge clk); #1;
    chk("kill_nodone", 64'(seen), 64'd0);
    chk("kill_hold32", {32'd0, res32}, exp_r32);
    chk("kill_hold64", res64, exp_r64);
    run_op("one", 1'b0, 8'd127, 23'h0, cls_of(1'b0, 8'd127, 23'h0), rm_rne_c, 1'b0);
    chk("one_const", got_r32, 64'd1);
    chk("one_noflag", 64'(got_f32), 64'd0);

    // randomized operands
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      s   = 1'($urandom);
      m   = 23'($urandom);
      case (sel)
        0: begin e = 8'd0; if ($urandom_range(0, 1) == 0) m = '0; end
        1: begin e = 8'hFF; if ($urandom_range(0, 1) == 0) m = '0; end
        2: e = 8'($urandom_range(100, 127));
        default: e = 8'($urandom_range(120, 195));
      endcase
      if ($urandom_range(0, 3) == 0) m[21:0] = '0; // exact halves and integers
      run_op("rnd", s, e, m, cls_of(s, e, m), 3'($urandom_range(0, 7)), 1'($urandom));
    end

    // reset in the middle of an operation
    sgn = 1'b0; expo = 8'd140; mant = 23'h0; cls = cls_of(1'b0, 8'd140, 23'h0); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #3;
    rstn = 1'b0; #1;
    chk("rstmid_res", {32'd0, res32} | res64, 64'd0);
    chk("rstmid_ctl", {54'd0, flg32, flg64}, 64'd0);
    chk("rstmid_busy", {60'd0, done32, done64, busy32, busy64}, 64'd0);
    #4; rstn = 1'b1;
    @(posedge clk); #1;
    run_op("post", 1'b1, 8'd130, 23'h340000, cls_of(1'b1, 8'd130, 23'h340000), rm_rdn_c, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
